bmac_acc: RTL
=============

Name: bmac_acc

Overview:
- Streaming binary multiply-accumulate engine; next generation of the XNOR/popcount BMAC.
- Each beat: XNOR of two IN_WIDTH-bit binary operand words, popcount, then accumulation over a variable-length vector delimited by `in_last`.
- Two modes: raw match-count (unsigned) or ±1 dot product (signed).
- Sits between the binary weight/activation fetch stage and the threshold/batch-norm stage.
- Valid/ready handshakes on both sides; pipelined, one beat per cycle.

Parameters:
- IN_WIDTH, 32, bits per operand word; must be ≥ 2.
- ACC_WIDTH, 16, accumulator and result width; must be ≥ clog2(IN_WIDTH+1)+1.
- CNT_WIDTH, 8, width of the beat counter reported with each result.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bmac_in_valid  in  1  input beat valid.
- bmac_in_ready  out  1  input beat accepted when valid&ready.
- bmac_in_0  in  IN_WIDTH  operand word A (bit 1 = +1, bit 0 = -1).
- bmac_in_1  in  IN_WIDTH  operand word B.
- bmac_in_last  in  1  beat is the final word of the vector.
- bmac_mode  in  1  0 = unsigned match count; 1 = signed dot product.
- bmac_out_valid  out  1  result valid.
- bmac_out_ready  in  1  downstream accepts the result.
- bmac_out  out  ACC_WIDTH  accumulated result (two's complement in mode 1).
- bmac_out_cnt  out  CNT_WIDTH  number of beats in the vector (saturating).
- bmac_out_sat  out  1  accumulator or counter saturated during this vector.

Behaviour:
- Reset (async assert, sync release): all valids 0; accumulator, bmac_out, bmac_out_cnt and bmac_out_sat 0; FSM in IDLE; any partial vector is discarded.
- Stall: stall = bmac_out_valid & ~bmac_out_ready. bmac_in_ready = ~stall. When stall is set, every pipeline register holds its value. This is combinational from bmac_out_ready; it is registered-safe because downstream does not depend on bmac_in_ready.
- Stage 1 (on accept): pop_q = popcount(~(bmac_in_0 ^ bmac_in_1)), width clog2(IN_WIDTH+1). Also register last_q and v1 = 1. With no accept and no stall, v1 = 0.
- Contribution per beat:
  - mode 0: c = pop_q, zero-extended.
  - mode 1: c = 2*pop_q − IN_WIDTH, sign-extended; range [−IN_WIDTH, +IN_WIDTH].
- Mode is latched on the first beat of a vector, while the FSM is in IDLE. Changes to bmac_mode mid-vector are ignored until the next vector.
- FSM:
  - IDLE: on v1 (not stalled), set acc = sat(c), cnt = 1, sat_flag = (saturated).
    - last_q = 1: load the output register and stay in IDLE.
    - last_q = 0: go to ACCUM.
  - ACCUM: on v1, set acc = sat(acc + c) and cnt = min(cnt+1, 2^CNT_WIDTH−1). sat_flag accumulates sticky saturation.
    - last_q = 1: load the output register and go to IDLE.
- Saturation:
  - mode 0: clamp at 2^ACC_WIDTH−1.
  - mode 1: clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - Compute the sum at ACC_WIDTH+1 bits before clamping.
  - Counter saturation also sets sat_flag.
- Output register: loaded when a last beat reaches stage 2. Sets bmac_out_valid = 1, with bmac_out = final acc, bmac_out_cnt = final cnt, bmac_out_sat = sat_flag. bmac_out_valid clears on bmac_out_ready unless a new result loads in the same cycle; back-to-back results are allowed.
- Latency: last beat accepted at edge t → bmac_out_valid high after edge t+2. Throughput is 1 beat/cycle with no bubbles between vectors.
- Single-beat vectors (in_last on the first beat) are legal.
- A new vector's first beat may follow a last beat on the very next cycle.
- Outputs hold stable while bmac_out_valid & ~bmac_out_ready.

Test Plan:
- Single beat, mode 0, both operands 0xFFFFFFFF, last=1 → 2 cycles later bmac_out = 32, cnt = 1, sat = 0.
- Single beat, mode 1, A = 0x00000000, B = 0xFFFFFFFF → bmac_out = 0xFFE0 (−32); then A = 0x0000FFFF, B = 0x0000FFFF → 32.
- Four beats, mode 1, A = B = 0xAAAAAAAA, last on the 4th; mode toggled to 0 on beat 2 → bmac_out = 128, cnt = 4 (mode change ignored).
- ACC_WIDTH = 8, mode 1, five matching beats (+32 each) → bmac_out = 127 (0x7F), sat = 1; next vector of one beat gives 32, sat = 0.
- Back-pressure: two single-beat vectors back-to-back with bmac_out_ready = 0 for 3 cycles → bmac_in_ready drops, first result held stable, both results delivered in order, none lost.
- rst_n asserted mid-vector after 2 beats → outputs 0 immediately; a following 1-beat vector yields cnt = 1 with no residue from before reset.

Source files
------------

// File: rtl/bmac_acc.sv
// rtl/bmac_acc.sv - streaming XNOR/popcount multiply-accumulate with valid/ready handshakes
module bmac_acc #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bmac_in_valid,
  output logic                 bmac_in_ready,
  input  logic [IN_WIDTH-1:0]  bmac_in_0,
  input  logic [IN_WIDTH-1:0]  bmac_in_1,
  input  logic                 bmac_in_last,
  input  logic                 bmac_mode,
  output logic                 bmac_out_valid,
  input  logic                 bmac_out_ready,
  output logic [ACC_WIDTH-1:0] bmac_out,
  output logic [CNT_WIDTH-1:0] bmac_out_cnt,
  output logic                 bmac_out_sat
);

  localparam int PW = $clog2(IN_WIDTH + 1);
  localparam int SW = ACC_WIDTH + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t               state, state_d;
  logic                 stall, accept;
  logic [IN_WIDTH-1:0]  match;
  logic [PW-1:0]        pop_d, pop_q;
  logic                 v1, last_q, mode_q;
  logic                 mode_r, eff_mode;
  logic [ACC_WIDTH-1:0] acc, acc_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic                 sat_flag, sat_d;
  logic                 done2;
  logic [SW-1:0]        pop_ext, c, base, sum;
  logic                 ovf, csat;

  // A held result freezes the whole pipeline; nothing downstream looks at in_ready.
  assign stall         = bmac_out_valid & ~bmac_out_ready;
  assign bmac_in_ready = ~stall;
  assign accept        = bmac_in_valid & ~stall;
  assign match         = ~(bmac_in_0 ^ bmac_in_1);

  // Count agreeing bit positions of the two operand words.
  always_comb begin
    pop_d = '0;
    for (int i = 0; i < IN_WIDTH; i++) pop_d = pop_d + PW'(match[i]);
  end

  // Stage 1: capture the beat's popcount, last flag and the mode it arrived with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      pop_q  <= '0;
      last_q <= 1'b0;
      mode_q <= 1'b0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        pop_q  <= pop_d;
        last_q <= bmac_in_last;
        mode_q <= bmac_mode;
      end
    end
  end

  // FSM state register; frozen while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      state <= IDLE;
    else if (!stall) state <= state_d;
  end

  // FSM next state: leave IDLE on a non-final first beat, return on the final beat.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (v1 && !last_q) state_d = ACCUM;
      ACCUM:   if (v1 && last_q)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: contribution, saturating sum, beat count and sticky saturation.
  always_comb begin
    // The first beat of a vector uses its own mode; later beats use the latched one.
    eff_mode = (state == IDLE) ? mode_q : mode_r;
    pop_ext  = SW'(pop_q);
    c        = eff_mode ? ((pop_ext << 1) - SW'(IN_WIDTH)) : pop_ext;
    if (state == IDLE) base = '0;
    else               base = eff_mode ? {acc[ACC_WIDTH-1], acc} : {1'b0, acc};
    sum   = base + c;
    ovf   = 1'b0;
    acc_d = sum[ACC_WIDTH-1:0];
    if (!eff_mode) begin
      if (sum[ACC_WIDTH]) begin
        ovf   = 1'b1;
        acc_d = '1;
      end
    end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
      ovf   = 1'b1;
      acc_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
    csat  = 1'b0;
    cnt_d = CNT_WIDTH'(1);
    if (state == ACCUM) begin
      if (&cnt) begin
        csat  = 1'b1;
        cnt_d = cnt;
      end else begin
        cnt_d = cnt + CNT_WIDTH'(1);
      end
    end
    sat_d = (state == IDLE) ? ovf : (sat_flag | ovf | csat);
  end

  // Stage 2: accumulator update; done2 marks that the final beat has just landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sat_flag <= 1'b0;
      mode_r   <= 1'b0;
      done2    <= 1'b0;
    end else if (!stall) begin
      done2 <= v1 & last_q;
      if (v1) begin
        acc      <= acc_d;
        cnt      <= cnt_d;
        sat_flag <= sat_d;
        if (state == IDLE) mode_r <= mode_q;
      end
    end
  end

  // Output register: publish a completed vector; the accumulator may already hold the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmac_out_valid <= 1'b0;
      bmac_out       <= '0;
      bmac_out_cnt   <= '0;
      bmac_out_sat   <= 1'b0;
    end else if (!stall) begin
      if (done2) begin
        bmac_out_valid <= 1'b1;
        bmac_out       <= acc;
        bmac_out_cnt   <= cnt;
        bmac_out_sat   <= sat_flag;
      end else begin
        bmac_out_valid <= 1'b0;
      end
    end
  end

endmodule
